// File: rtl/osc_seq_pkg.sv
// Shared types and default timing constants for the oscillator/PLL clock sequencer.
package osc_seq_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_INIT = 3'd0,
    ST_PLL_OFF   = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_STABLE    = 3'd3,
    ST_RELEASE   = 3'd4,
    ST_RUN       = 3'd5,
    ST_FAULT     = 3'd6
  } state_e;

  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_LOCK_TIMEOUT  = 16000;
  localparam int DEF_HOLD_CYCLES   = 16;
  localparam int DEF_MAX_RETRIES   = 3;

  // The PLL is powered in every state that waits on, or relies on, lock.
  function automatic logic pll_enabled(input state_e st);
    logic en;
    case (st)
      ST_WAIT_LOCK: en = 1'b1;
      ST_STABLE:    en = 1'b1;
      ST_RELEASE:   en = 1'b1;
      ST_RUN:       en = 1'b1;
      default:      en = 1'b0;
    endcase
    return en;
  endfunction

  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    logic [1:0] r;
    if (v == 2'd3) begin
      r = v;
    end else begin
      r = v + 2'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the CLK domain.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // meta_q may go metastable; only sync_q is consumed downstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/osc_clock_sequencer.sv
// Brings up the PLL from the on-chip oscillator, waits for a stable lock and
// then releases fabric reset; retries a slow lock and latches FAULT when out of attempts.
module osc_clock_sequencer
  import osc_seq_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       INIT_DONE,
  input  logic       PLL_LOCK,
  input  logic       SW_RESET_REQ,
  output logic       PLL_POWERDOWN_N,
  output logic       FABRIC_RESET_N,
  output logic       READY,
  output logic       FAULT,
  output logic [2:0] STATE,
  output logic [1:0] RETRY_CNT
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
  localparam int TO_W   = $clog2(LOCK_TIMEOUT) + 1;
  localparam int STAB_W = $clog2(STABLE_CYCLES) + 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [2:0]        RETRY_MAX = 3'(MAX_RETRIES);

  logic rst_sync_n;
  logic init_s;
  logic lock_s;

  state_e            state_q,  state_d;
  logic [HOLD_W-1:0] hold_q,   hold_d;
  logic [TO_W-1:0]   to_q,     to_d;
  logic [STAB_W-1:0] stab_q,   stab_d;
  logic [1:0]        retry_q,  retry_d;
  logic              pd_n_q,   pd_n_d;
  logic              frst_n_q, frst_n_d;
  logic              ready_q,  ready_d;
  logic              fault_q,  fault_d;
  logic [2:0]        retry_next_s;

  // Reset asserts immediately through the synchronizer's async clear and
  // releases two edges later.
  sync_2ff u_rst_sync (
    .clk   (CLK),
    .rst_n (RESETN),
    .d     (1'b1),
    .q     (rst_sync_n)
  );

  sync_2ff u_init_sync (
    .clk   (CLK),
    .rst_n (RESETN),
    .d     (INIT_DONE),
    .q     (init_s)
  );

  sync_2ff u_lock_sync (
    .clk   (CLK),
    .rst_n (RESETN),
    .d     (PLL_LOCK),
    .q     (lock_s)
  );

  assign retry_next_s = {1'b0, retry_q} + 3'd1;

  // Next-state and counter update; INIT_DONE loss outranks a software restart,
  // which outranks lock loss and counter expiry.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    to_d    = to_q;
    stab_d  = stab_q;
    retry_d = retry_q;
    if ((state_q != ST_WAIT_INIT) && !init_s) begin
      state_d = ST_WAIT_INIT;
      hold_d  = HOLD_W'(0);
      to_d    = TO_W'(0);
      stab_d  = STAB_W'(0);
      retry_d = 2'd0;
    end else if ((state_q != ST_WAIT_INIT) && SW_RESET_REQ) begin
      state_d = ST_PLL_OFF;
      hold_d  = HOLD_W'(0);
      to_d    = TO_W'(0);
      stab_d  = STAB_W'(0);
      retry_d = 2'd0;
    end else begin
      case (state_q)
        ST_WAIT_INIT: begin
          hold_d  = HOLD_W'(0);
          to_d    = TO_W'(0);
          stab_d  = STAB_W'(0);
          retry_d = 2'd0;
          if (init_s) begin
            state_d = ST_PLL_OFF;
          end else begin
            state_d = ST_WAIT_INIT;
          end
        end
        ST_PLL_OFF: begin
          to_d   = TO_W'(0);
          stab_d = STAB_W'(0);
          if (hold_q >= HOLD_LAST) begin
            state_d = ST_WAIT_LOCK;
            hold_d  = HOLD_W'(0);
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = ST_STABLE;
            stab_d  = STAB_W'(0);
          end else if (to_q >= TO_LAST) begin
            retry_d = sat_inc2(retry_q);
            hold_d  = HOLD_W'(0);
            to_d    = TO_W'(0);
            if (retry_next_s >= RETRY_MAX) begin
              state_d = ST_FAULT;
            end else begin
              state_d = ST_PLL_OFF;
            end
          end else begin
            to_d = to_q + TO_W'(1);
          end
        end
        ST_STABLE: begin
          // the timeout budget is kept across a lock glitch, not restarted
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            stab_d  = STAB_W'(0);
          end else if (stab_q >= STAB_LAST) begin
            state_d = ST_RELEASE;
            stab_d  = STAB_W'(0);
            hold_d  = HOLD_W'(0);
          end else begin
            stab_d = stab_q + STAB_W'(1);
          end
        end
        ST_RELEASE: begin
          if (hold_q >= HOLD_LAST) begin
            state_d = ST_RUN;
            hold_d  = HOLD_W'(0);
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_d = ST_PLL_OFF;
            hold_d  = HOLD_W'(0);
            to_d    = TO_W'(0);
            stab_d  = STAB_W'(0);
            retry_d = 2'd0;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_WAIT_INIT;
          hold_d  = HOLD_W'(0);
          to_d    = TO_W'(0);
          stab_d  = STAB_W'(0);
          retry_d = 2'd0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they flip on the same edge as STATE.
  always_comb begin
    pd_n_d   = pll_enabled(state_d);
    frst_n_d = (state_d == ST_RUN);
    ready_d  = (state_d == ST_RUN);
    fault_d  = (state_d == ST_FAULT);
  end

  // Sequencer state, counters and registered outputs.
  always_ff @(posedge CLK or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q  <= ST_WAIT_INIT;
      hold_q   <= HOLD_W'(0);
      to_q     <= TO_W'(0);
      stab_q   <= STAB_W'(0);
      retry_q  <= 2'd0;
      pd_n_q   <= 1'b0;
      frst_n_q <= 1'b0;
      ready_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      to_q     <= to_d;
      stab_q   <= stab_d;
      retry_q  <= retry_d;
      pd_n_q   <= pd_n_d;
      frst_n_q <= frst_n_d;
      ready_q  <= ready_d;
      fault_q  <= fault_d;
    end
  end

  assign PLL_POWERDOWN_N = pd_n_q;
  assign FABRIC_RESET_N  = frst_n_q;
  assign READY           = ready_q;
  assign FAULT           = fault_q;
  assign STATE           = state_q;
  assign RETRY_CNT       = retry_q;

endmodule

// File: tb/tb_osc_clock_sequencer.sv
// Directed bench for osc_clock_sequencer with short timing parameters.
module tb_osc_clock_sequencer;

  localparam logic [2:0] S_WAIT_INIT = 3'd0;
  localparam logic [2:0] S_PLL_OFF   = 3'd1;
  localparam logic [2:0] S_WAIT_LOCK = 3'd2;
  localparam logic [2:0] S_STABLE    = 3'd3;
  localparam logic [2:0] S_RELEASE   = 3'd4;
  localparam logic [2:0] S_RUN       = 3'd5;
  localparam logic [2:0] S_FAULT     = 3'd6;

  logic       CLK;
  logic       RESETN;
  logic       INIT_DONE;
  logic       PLL_LOCK;
  logic       SW_RESET_REQ;
  logic       PLL_POWERDOWN_N;
  logic       FABRIC_RESET_N;
  logic       READY;
  logic       FAULT;
  logic [2:0] STATE;
  logic [1:0] RETRY_CNT;

  int   compared   = 0;
  int   mismatched = 0;
  int   n;
  logic fr_early   = 1'b0;
  logic rdy_split  = 1'b0;

  osc_clock_sequencer #(
    .STABLE_CYCLES (8),
    .LOCK_TIMEOUT  (100),
    .HOLD_CYCLES   (4),
    .MAX_RETRIES   (2)
  ) dut (
    .CLK             (CLK),
    .RESETN          (RESETN),
    .INIT_DONE       (INIT_DONE),
    .PLL_LOCK        (PLL_LOCK),
    .SW_RESET_REQ    (SW_RESET_REQ),
    .PLL_POWERDOWN_N (PLL_POWERDOWN_N),
    .FABRIC_RESET_N  (FABRIC_RESET_N),
    .READY           (READY),
    .FAULT           (FAULT),
    .STATE           (STATE),
    .RETRY_CNT       (RETRY_CNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Fabric reset may only be released in RUN, and always together with READY.
  always @(negedge CLK) begin
    if (FABRIC_RESET_N === 1'b1 && STATE !== S_RUN) fr_early <= 1'b1;
    if (FABRIC_RESET_N !== READY) rdy_split <= 1'b1;
  end

  task automatic tick(input int cycles);
    repeat (cycles) @(negedge CLK);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int maxc, input string tag);
    int k;
    k = 0;
    while (STATE !== s && k < maxc) begin
      tick(1);
      k++;
    end
    check(tag, {29'd0, STATE}, {29'd0, s});
  endtask

  task automatic dur(input logic [2:0] s, input int maxc, output int len);
    len = 0;
    while (STATE === s && len < maxc) begin
      len++;
      tick(1);
    end
  endtask

  initial begin
    RESETN       = 1'b0;
    INIT_DONE    = 1'b0;
    PLL_LOCK     = 1'b0;
    SW_RESET_REQ = 1'b0;
    tick(3);
    check("rst_state", {29'd0, STATE}, {29'd0, S_WAIT_INIT});
    check("rst_pd_n",  {31'd0, PLL_POWERDOWN_N}, 32'd0);
    check("rst_frst_n", {31'd0, FABRIC_RESET_N}, 32'd0);
    check("rst_ready", {31'd0, READY}, 32'd0);
    check("rst_fault", {31'd0, FAULT}, 32'd0);
    check("rst_retry", {30'd0, RETRY_CNT}, 32'd0);

    // Nominal bring-up
    RESETN    = 1'b1;
    INIT_DONE = 1'b1;
    tick(2);
    check("no_early_exit", {29'd0, STATE}, {29'd0, S_WAIT_INIT});
    tick(1);
    check("enter_pll_off", {29'd0, STATE}, {29'd0, S_PLL_OFF});
    dur(S_PLL_OFF, 50, n);
    check("pll_off_len", n, 32'd4);
    check("wait_lock_pd_n", {31'd0, PLL_POWERDOWN_N}, 32'd1);
    tick(9);
    PLL_LOCK = 1'b1;
    dur(S_WAIT_LOCK, 50, n);
    check("lock_sync_lat", n, 32'd3);
    dur(S_STABLE, 50, n);
    check("stable_len", n, 32'd8);
    check("enter_release", {29'd0, STATE}, {29'd0, S_RELEASE});
    check("release_frst_n", {31'd0, FABRIC_RESET_N}, 32'd0);
    dur(S_RELEASE, 50, n);
    check("release_len", n, 32'd4);
    check("run_state", {29'd0, STATE}, {29'd0, S_RUN});
    check("run_ready", {31'd0, READY}, 32'd1);
    check("run_frst_n", {31'd0, FABRIC_RESET_N}, 32'd1);

    // Lock loss in RUN
    PLL_LOCK = 1'b0;
    tick(2);
    check("run_hold_ready", {31'd0, READY}, 32'd1);
    tick(1);
    check("drop_state", {29'd0, STATE}, {29'd0, S_PLL_OFF});
    check("drop_ready", {31'd0, READY}, 32'd0);
    check("drop_frst_n", {31'd0, FABRIC_RESET_N}, 32'd0);

    // Lock timeout, retry, then FAULT
    dur(S_PLL_OFF, 50, n);
    check("retry0_off_len", n, 32'd4);
    dur(S_WAIT_LOCK, 200, n);
    check("timeout1_len", n, 32'd100);
    check("timeout1_state", {29'd0, STATE}, {29'd0, S_PLL_OFF});
    check("timeout1_retry", {30'd0, RETRY_CNT}, 32'd1);
    dur(S_PLL_OFF, 50, n);
    check("retry1_off_len", n, 32'd4);
    dur(S_WAIT_LOCK, 200, n);
    check("timeout2_len", n, 32'd100);
    check("fault_state", {29'd0, STATE}, {29'd0, S_FAULT});
    check("fault_flag", {31'd0, FAULT}, 32'd1);
    check("fault_pd_n", {31'd0, PLL_POWERDOWN_N}, 32'd0);
    check("fault_retry", {30'd0, RETRY_CNT}, 32'd2);
    tick(5);
    check("fault_sticky", {29'd0, STATE}, {29'd0, S_FAULT});

    // Software recovery from FAULT
    SW_RESET_REQ = 1'b1;
    PLL_LOCK     = 1'b1;
    tick(1);
    SW_RESET_REQ = 1'b0;
    check("recover_state", {29'd0, STATE}, {29'd0, S_PLL_OFF});
    check("recover_retry", {30'd0, RETRY_CNT}, 32'd0);
    check("recover_fault", {31'd0, FAULT}, 32'd0);
    wait_state(S_RUN, 60, "recover_run");
    check("recover_ready", {31'd0, READY}, 32'd1);

    // Software restart from RUN, then a one-cycle lock glitch in STABLE
    SW_RESET_REQ = 1'b1;
    tick(1);
    SW_RESET_REQ = 1'b0;
    check("sw_run_state", {29'd0, STATE}, {29'd0, S_PLL_OFF});
    wait_state(S_STABLE, 30, "glitch_reach_stable");
    tick(3);
    PLL_LOCK = 1'b0;
    tick(1);
    PLL_LOCK = 1'b1;
    tick(1);
    check("glitch_pre_drop", {29'd0, STATE}, {29'd0, S_STABLE});
    tick(1);
    check("glitch_back", {29'd0, STATE}, {29'd0, S_WAIT_LOCK});
    dur(S_WAIT_LOCK, 50, n);
    check("glitch_wl_len", n, 32'd1);
    dur(S_STABLE, 50, n);
    check("glitch_stable_len", n, 32'd8);
    wait_state(S_RUN, 20, "glitch_run");
    check("no_early_frst", {31'd0, fr_early}, 32'd0);
    check("ready_with_frst", {31'd0, rdy_split}, 32'd0);

    // INIT_DONE loss and SW request on the same edge
    INIT_DONE = 1'b0;
    tick(2);
    check("init_drop_pending", {29'd0, STATE}, {29'd0, S_RUN});
    SW_RESET_REQ = 1'b1;
    tick(1);
    SW_RESET_REQ = 1'b0;
    check("prio_state", {29'd0, STATE}, {29'd0, S_WAIT_INIT});
    check("prio_ready", {31'd0, READY}, 32'd0);
    check("prio_pd_n", {31'd0, PLL_POWERDOWN_N}, 32'd0);
    SW_RESET_REQ = 1'b1;
    tick(1);
    SW_RESET_REQ = 1'b0;
    check("sw_ignored_wait_init", {29'd0, STATE}, {29'd0, S_WAIT_INIT});

    // Asynchronous reset in the middle of STABLE
    INIT_DONE = 1'b1;
    wait_state(S_STABLE, 40, "reset_reach_stable");
    tick(2);
    check("mid_stable_pd_n", {31'd0, PLL_POWERDOWN_N}, 32'd1);
    #2;
    RESETN = 1'b0;
    #1;
    check("async_rst_state", {29'd0, STATE}, {29'd0, S_WAIT_INIT});
    check("async_rst_pd_n", {31'd0, PLL_POWERDOWN_N}, 32'd0);
    check("async_rst_frst_n", {31'd0, FABRIC_RESET_N}, 32'd0);
    check("async_rst_ready", {31'd0, READY}, 32'd0);
    check("async_rst_fault", {31'd0, FAULT}, 32'd0);
    check("async_rst_retry", {30'd0, RETRY_CNT}, 32'd0);
    tick(2);
    check("rst_held_state", {29'd0, STATE}, {29'd0, S_WAIT_INIT});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/osc_clock_sequencer.md
OSC_CLOCK_SEQUENCER -- requirements
Module: osc_clock_sequencer

Interface
REQ-001 Parameter STABLE_CYCLES, default 1024: cycles PLL_LOCK must stay high before release.
REQ-002 Parameter LOCK_TIMEOUT, default 16000: cycles (100 us at 160 MHz) allowed for lock per attempt.
REQ-003 Parameter HOLD_CYCLES, default 16: minimum cycles PLL_POWERDOWN_N and FABRIC_RESET_N stay low per assertion.
REQ-004 Parameter MAX_RETRIES, default 3: PLL restart attempts before FAULT.
REQ-005 Ports, one per line:
  CLK  input  1  RCOSC_160MHZ_GL on-chip oscillator clock; one clock domain.
  RESETN  input  1  asynchronous active-low reset.
  INIT_DONE  input  1  device init complete; asynchronous to CLK.
  PLL_LOCK  input  1  PLL lock indicator; asynchronous to CLK.
  SW_RESET_REQ  input  1  synchronous single-cycle request to rerun the sequence.
  PLL_POWERDOWN_N  output  1  PLL enable, low holds PLL in power-down.
  FABRIC_RESET_N  output  1  fabric reset, low holds fabric logic in reset.
  READY  output  1  high only in RUN.
  FAULT  output  1  high only in FAULT.
  STATE  output  3  current state encoding.
  RETRY_CNT  output  2  attempts consumed in the current sequence.

Function
REQ-006 INIT_DONE and PLL_LOCK SHALL pass through a 2-FF synchronizer; the FSM reacts to a change 2 cycles after it is sampled.
REQ-007 States: WAIT_INIT=0, PLL_OFF=1, WAIT_LOCK=2, STABLE=3, RELEASE=4, RUN=5, FAULT=6.
REQ-008 WAIT_INIT: PLL_POWERDOWN_N=0, FABRIC_RESET_N=0. Go to PLL_OFF when synced INIT_DONE=1.
REQ-009 PLL_OFF: PLL_POWERDOWN_N=0 for exactly HOLD_CYCLES cycles, then WAIT_LOCK.
REQ-010 WAIT_LOCK: PLL_POWERDOWN_N=1. Go to STABLE on synced lock=1.
REQ-010a WAIT_LOCK timeout: when the timeout counter reaches LOCK_TIMEOUT, increment RETRY_CNT. Go to PLL_OFF if the new RETRY_CNT < MAX_RETRIES, otherwise go to FAULT.
REQ-011 STABLE: count consecutive locked cycles. A lock drop returns to WAIT_LOCK with the stable count cleared and the timeout counter continuing. Go to RELEASE after STABLE_CYCLES consecutive locked cycles.
REQ-012 RELEASE: FABRIC_RESET_N stays 0 for HOLD_CYCLES further cycles, then RUN. FABRIC_RESET_N rises on the first RUN cycle.
REQ-013 RUN: READY=1, FABRIC_RESET_N=1. Go to PLL_OFF on a lock drop or on SW_RESET_REQ.
REQ-013a RUN exit: FABRIC_RESET_N and READY fall in the same cycle the FSM enters PLL_OFF. RETRY_CNT clears.
REQ-014 FAULT: PLL_POWERDOWN_N=0, FABRIC_RESET_N=0, FAULT=1. Sticky; leave only via SW_RESET_REQ (goes to PLL_OFF, RETRY_CNT cleared) or RESETN.
REQ-015 Synced INIT_DONE falling in any state other than WAIT_INIT SHALL force WAIT_INIT next cycle, with all counters cleared.
REQ-016 Simultaneous events, highest priority first: INIT_DONE drop, then SW_RESET_REQ, then lock drop, then counter expiry.
REQ-017 SW_RESET_REQ in WAIT_INIT SHALL be ignored.
REQ-017a SW_RESET_REQ in PLL_OFF, WAIT_LOCK, STABLE or RELEASE SHALL restart PLL_OFF with the hold count and RETRY_CNT cleared.
REQ-018 Counters SHALL be sized with $clog2 of their limit plus 1, SHALL saturate, and SHALL never wrap.
REQ-019 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-020 RESETN low SHALL asynchronously set, and hold while low: STATE=WAIT_INIT, PLL_POWERDOWN_N=0, FABRIC_RESET_N=0, READY=0, FAULT=0, RETRY_CNT=0, all counters 0, synchronizer flops 0.
REQ-021 RESETN deassertion SHALL be synchronized in-block (async assert, 2-FF sync release). The FSM leaves WAIT_INIT no earlier than 2 cycles after release.

Structure
REQ-022 A shared package osc_seq_pkg SHALL hold the state enum (3-bit) and the default parameter constants.
REQ-023 The 2-FF synchronizer SHALL be a separate sub-module, sync_2ff, instantiated three times (INIT_DONE, PLL_LOCK, RESETN release).

Verification (STABLE_CYCLES=8, LOCK_TIMEOUT=100, HOLD_CYCLES=4, MAX_RETRIES=2)
REQ-024 Nominal: INIT_DONE=1, then PLL_LOCK=1 on cycle 10 of WAIT_LOCK -> PLL_OFF lasts 4 cycles, STABLE lasts 8, RELEASE lasts 4; READY=1 and FABRIC_RESET_N=1 together.
REQ-025 Lock glitch: PLL_LOCK low for 1 cycle at STABLE count 5 -> return to WAIT_LOCK, then a full 8-cycle STABLE; FABRIC_RESET_N never pulses high.
REQ-026 Timeout: PLL_LOCK stuck 0 -> RETRY_CNT=1 after 100 WAIT_LOCK cycles, back to PLL_OFF; FAULT=1 after the second timeout, with PLL_POWERDOWN_N=0.
REQ-027 RUN disturbance: PLL_LOCK drops in RUN -> next cycle READY=0 and FABRIC_RESET_N=0, STATE=PLL_OFF; a SW_RESET_REQ in FAULT recovers to RUN once lock returns.
REQ-028 Simultaneous events: INIT_DONE drop and SW_RESET_REQ in the same cycle -> WAIT_INIT wins.
REQ-028a Reset mid-operation: RESETN asserted mid-STABLE -> all outputs at reset values within the same cycle, asynchronously.
